// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: multi-stage Gray pointer synchroniser with binary decode, change/stable flags.
// Optional Gray-integrity checker enabled by defining GRAY_PTR_SYNC_CHK_EN.
module gray_ptr_sync #(
    parameter int WIDTH         = 4,
    parameter int STAGES        = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ptr_gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] ptr_gray_out,
    output logic [WIDTH-1:0] ptr_bin_out,
    output logic             ptr_changed,
    output logic             ptr_stable,
    output logic             ptr_err
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
    if (STAGES < 2) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be >= 2");
    end
    logic [WIDTH-1:0] sync [STAGES];
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt;
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) sync[k] <= '0;
            prev <= '0;
            cnt  <= '0;
        end else begin
            sync[0] <= ptr_gray_in;
            for (int k = 1; k < STAGES; k++) sync[k] <= sync[k-1];
            prev <= ptr_gray_out;
            cnt  <= ptr_changed ? '0 : (cnt < CMAX ? cnt + CW'(1) : cnt);
        end
    end
    assign ptr_gray_out = sync[STAGES-1];
    assign ptr_changed  = ptr_gray_out != prev;
    assign ptr_stable   = (cnt == CMAX) && !ptr_changed;
    always_comb begin
        ptr_bin_out = '0;
        for (int i = 0; i < WIDTH; i++) ptr_bin_out[i] = ^(ptr_gray_out >> i);
    end
`ifdef GRAY_PTR_SYNC_CHK_EN
    logic viol;
    assign viol = $countones(ptr_gray_out ^ prev) > 1;
    // A fresh violation outranks a coincident clear.
    always_ff @(posedge clk_in) begin
        if (!rst_n) ptr_err <= 1'b0;
        else if (viol) ptr_err <= 1'b1;
        else if (err_clr) ptr_err <= 1'b0;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ptr_err = 1'b0;
`endif
endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Parametrised multi-stage synchroniser for Gray-coded FIFO pointers crossing into the `clk_in` domain. It generalises the fixed 4-bit, 2-flop pointer synchroniser to configurable width and depth. It also adds Gray-to-binary decode, a new-value pulse, a settle/stability indicator and an optional Gray-coding integrity checker. It sits on each side of the async FIFO, between the remote pointer register and the local full/empty logic.

## Interface
Parameters:
- `WIDTH`, 4: pointer width in bits; must be ≥1.
- `STAGES`, 2: synchroniser flop depth; must be ≥2, otherwise elaboration error.
- `STABLE_CYCLES`, 3: consecutive unchanged cycles before `ptr_stable` asserts; must be ≥1.

Ports:
- `clk_in`  in  1  destination-domain clock.
- `rst_n`  in  1  **reset, synchronous, active-low**; one clock, `clk_in`.
- `ptr_gray_in`  in  WIDTH  Gray pointer from the source domain; asynchronous to `clk_in`.
- `err_clr`  in  1  clears sticky `ptr_err`; synchronous.
- `ptr_gray_out`  out  WIDTH  synchronised Gray pointer.
- `ptr_bin_out`  out  WIDTH  binary decode of `ptr_gray_out`.
- `ptr_changed`  out  1  one-cycle pulse on a new `ptr_gray_out` value.
- `ptr_stable`  out  1  output unchanged for ≥`STABLE_CYCLES` cycles.
- `ptr_err`  out  1  sticky Gray-violation flag; exists only with the macro, otherwise tied 0.

## Operation
- Sync chain `sync[0..STAGES-1]`:
  - `sync[0]` samples `ptr_gray_in`; `sync[k]` takes `sync[k-1]`.
  - `ptr_gray_out` = `sync[STAGES-1]`.
  - `sync[0]` is the only flop fed by an asynchronous signal.
- `ptr_bin_out`: combinational decode of `ptr_gray_out`. `bin[WIDTH-1]=g[WIDTH-1]`; `bin[i]=bin[i+1]^g[i]`.
- `prev` register: `prev <= ptr_gray_out` every cycle.
- `ptr_changed = (ptr_gray_out != prev)`. It is high exactly in the first cycle a new value is presented.
- Stability counter `cnt`:
  - Width `$clog2(STABLE_CYCLES+1)`.
  - Next value: if `ptr_changed`, `cnt <= 0`; else if `cnt < STABLE_CYCLES`, increment; else saturate (no wrap).
  - `ptr_stable = (cnt == STABLE_CYCLES) && !ptr_changed`.
- Wrap-around, e.g. binary 15→0 (Gray `1000`→`0000`), is an ordinary single-bit change: `ptr_changed` pulses, no error.
- Reset, including mid-operation: with `rst_n` low at a rising edge, all of the following clear to 0 at that edge:
  - every sync stage, `prev`, `cnt` and `ptr_err`.
  - Outputs while in reset: `ptr_gray_out=0`, `ptr_bin_out=0`, `ptr_changed=0`, `ptr_stable=0`, `ptr_err=0`.
  - Input values captured before reset are discarded.

## Timing
- Latency: a value captured by `sync[0]` at edge t appears on `ptr_gray_out`/`ptr_bin_out` after edge t+STAGES-1. Example: `STAGES=2` gives output after the next edge.
- `ptr_changed` is coincident with the new output value and lasts 1 cycle per change. Back-to-back changes give back-to-back pulses.
- `ptr_stable` deasserts in the change cycle. It reasserts after `STABLE_CYCLES` further edges without a change, counted from the edge following the change cycle.
- After reset release with a constant input, `ptr_stable` rises after the `STABLE_CYCLES`-th active edge.
- `ptr_err` sets at the edge following a violating cycle.
- Simultaneous `err_clr` and a new violation: set wins.

## Configuration
- Macro `GRAY_PTR_SYNC_CHK_EN`.
- Defined: a checker computes `popcount(ptr_gray_out ^ prev)`.
  - A count >1 is a violation: a non-Gray source or a metastability-induced skip.
  - A violation sets `ptr_err`, which stays high until `err_clr=1` at an edge.
  - `prev` is reused; no additional latency on data outputs.
- Undefined: no checker logic is built. `ptr_err` is a constant 0 and `err_clr` is ignored.
- All other behaviour is identical in both builds.

## Test plan
- Reset: `rst_n=0` for 3 edges with `ptr_gray_in=4'hF` → all outputs 0.
  - Then release with input 0 and `STABLE_CYCLES=3` → `ptr_stable` rises after the 3rd edge, `ptr_changed` never pulses.
- Latency, `WIDTH=4`, `STAGES=2`: input `0000`→`0001` captured at edge t → after edge t+1, `ptr_gray_out=0001`, `ptr_bin_out=1`, `ptr_changed` high 1 cycle, `ptr_stable` low. `ptr_stable` returns high after 3 quiet edges.
  - Repeat with `STAGES=3` → output after edge t+2.
- Full Gray count 0..15 and wrap to 0, holding each value 4 cycles → `ptr_bin_out` follows 0..15,0. 16 `ptr_changed` pulses, including the 15→0 wrap, which is a normal change and not an error. `ptr_err=0`.
- Checker build: input `0000`→`0011` → `ptr_err=1` one edge after the change cycle and stays high.
  - `err_clr` pulse → 0.
  - New violation coincident with `err_clr` → `ptr_err` remains 1.
  - Non-checker build, same stimulus → `ptr_err` always 0.
- Reset mid-operation: `rst_n` low for 1 edge while `ptr_stable=1` and the output is `0101` → the next cycle shows all outputs 0. After release with input `0101` → new value after `STAGES` edges with one `ptr_changed` pulse.
